tanh_grad: RTL and testbench

TANH_GRAD -- requirements
Module: tanh_grad

---
 rtl/tanh_grad_pkg.sv | 10 +
 rtl/tanh_grad_mul.sv | 25 ++
 rtl/tanh_grad.sv | 74 +++++++
 tb/tb_tanh_grad.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_grad_pkg.sv
// Fixed-point defaults and constants shared by the tanh forward and backward blocks.
`timescale 1ns/1ps
package tanh_grad_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int FL_DEF    = 24;
  localparam int STAGES    = 3;

  localparam logic [31:0] ONE_POS = 32'h0100_0000;
  localparam logic [31:0] ONE_NEG = 32'hFF00_0000;
endpackage

// File: rtl/tanh_grad_mul.sv
// fx_mul: signed WIDTH x WIDTH fixed-point multiply, >>> FL, WIDTH-bit result.
// TANH_GRAD_ROUND_EN selects round-half-up instead of floor on the shift.
`timescale 1ns/1ps
module fx_mul #(
  parameter int WIDTH = 32,
  parameter int FL    = 24
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] adj;

  assign full = a * b;

`ifdef TANH_GRAD_ROUND_EN
  localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(1) << (FL - 1);
  assign adj = full + RND;
`else
  assign adj = full;
`endif

  assign p = WIDTH'(adj >>> FL);
endmodule

// File: rtl/tanh_grad.sv
// tanh backward pass, d = g*(1 - y^2), 3-stage valid/ready pipeline.
// Optional macro TANH_GRAD_ROUND_EN enables round-half-up in both multiplies.
`timescale 1ns/1ps
module tanh_grad
  import tanh_grad_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FL    = FL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] g_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             busy
);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FL;

  logic [STAGES:1]         vld_pipe;
  logic signed [WIDTH-1:0] s1_ysq, s1_g, s2_prod, d_q;
  logic signed [WIDTH-1:0] ysq_w, om_raw, om, prod_w;
  logic                    adv;

  assign adv       = en && (!vld_pipe[STAGES] || out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign busy      = |vld_pipe;
  assign d_out     = d_q;

  fx_mul #(.WIDTH(WIDTH), .FL(FL)) u_sq (
    .a (y_in),
    .b (y_in),
    .p (ysq_w)
  );

  // Clamp keeps |g*om| <= |g|, so the product never needs saturation.
  always_comb begin
    om_raw = ONE - s1_ysq;
    om     = om_raw;
    if (om_raw[WIDTH-1])
      om = '0;
    else if (om_raw > ONE)
      om = ONE;
  end

  fx_mul #(.WIDTH(WIDTH), .FL(FL)) u_gm (
    .a (s1_g),
    .b (om),
    .p (prod_w)
  );

  // d_out only reloads when a valid sample enters S3, so it stays put across bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_ysq   <= '0;
      s1_g     <= '0;
      s2_prod  <= '0;
      d_q      <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_ysq   <= ysq_w;
      s1_g     <= g_in;
      s2_prod  <= prod_w;
      if (vld_pipe[STAGES-1])
        d_q <= s2_prod;
    end
  end
endmodule

// File: tb/tb_tanh_grad.sv
// Scoreboard bench for tanh_grad: driver pushes expected results, monitor pops on output transfer.
`timescale 1ns/1ps
module tb_tanh_grad;
  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h0100_0000;

  logic         clk = 1'b0, rst = 1'b0, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] y_in = '0, g_in = '0, d_out;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  tanh_grad #(.WIDTH(W), .FL(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .g_in      (g_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: an output transfer is sampled 2 ns before the rising edge.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h, expected no output", d_out);
      end else begin
        check("d_out", d_out, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] y, input logic [W-1:0] g, input logic [W-1:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    y_in     = y;
    g_in     = g;
    for (int t = 0; t < 50; t++) begin
      #2;
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check(name, W'(exp_q.size()), '0);
  endtask

  function automatic logic [W-1:0] bp_exp(input int k);
    return ONE - W'(k * k * 32'h0004_0000);
  endfunction

  logic [W-1:0] vy[8], vg[8], ve[8];
  int           cnt, idx;

  initial begin
    vy[0] = 32'h0000_0000; vg[0] = ONE;          ve[0] = ONE;
    vy[1] = 32'h0080_0000; vg[1] = ONE;          ve[1] = 32'h00C0_0000;
    vy[2] = 32'hFF80_0000; vg[2] = 32'hFE00_0000; ve[2] = 32'hFE80_0000;
    vy[3] = ONE;           vg[3] = ONE;          ve[3] = 32'h0000_0000;
    vy[4] = 32'h0200_0000; vg[4] = ONE;          ve[4] = 32'h0000_0000;
    vy[5] = 32'hFF00_0000; vg[5] = 32'h0030_0000; ve[5] = 32'h0000_0000;
    vy[6] = 32'h0000_0000; vg[6] = 32'hFF00_0000; ve[6] = 32'hFF00_0000;
    vy[7] = 32'h0080_0000; vg[7] = 32'h0000_0002;
`ifdef TANH_GRAD_ROUND_EN
    ve[7] = 32'h0000_0002;
`else
    ve[7] = 32'h0000_0001;
`endif

    // Reset state
    en = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_d_out", d_out, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b1;

    // Latency of a lone sample
    send(32'h0, ONE, ONE);
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      cnt++;
      if (out_valid) break;
    end
    check("latency", W'(cnt), W'(3));
    drain("drain_latency");

    // Directed vectors, back-to-back
    for (int i = 0; i < 8; i++) send(vy[i], vg[i], ve[i]);
    idle(1);
    drain("drain_directed");

    // Backpressure: out_ready low on cycles 4..7
    idx = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      out_ready = !(t >= 4 && t <= 7);
      if (idx < 8) begin
        in_valid = 1'b1;
        y_in     = W'(idx * 32'h0020_0000);
        g_in     = ONE;
      end else begin
        in_valid = 1'b0;
      end
      #2;
      if (t >= 4 && t <= 7) begin
        check("bp_in_ready", W'(in_ready), '0);
        check("bp_out_valid", W'(out_valid), W'(1));
        check("bp_d_out_held", d_out, bp_exp(1));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bp_exp(idx));
        idx++;
      end
    end
    check("bp_accepted", W'(idx), W'(8));
    idle(1);
    drain("drain_bp");

    // Reset with three samples in flight
    out_ready = 1'b1;
    send(vy[1], vg[1], ve[1]);
    send(vy[2], vg[2], ve[2]);
    send(vy[6], vg[6], ve[6]);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    #3;
    check("mid_rst_out_valid", W'(out_valid), '0);
    check("mid_rst_busy", W'(busy), '0);
    idle(8);
    #3;
    check("post_rst_busy", W'(busy), '0);

    // Enable low freezes everything
    send(vy[1], vg[1], ve[1]);
    send(vy[0], vg[0], ve[0]);
    send(vy[2], vg[2], ve[2]);
    @(negedge clk);
    en        = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    y_in      = 32'h0040_0000;
    g_in      = ONE;
    for (int t = 0; t < 3; t++) begin
      #2;
      check("en_in_ready", W'(in_ready), '0);
      check("en_out_valid", W'(out_valid), W'(1));
      check("en_d_out", d_out, ve[1]);
      check("en_busy", W'(busy), W'(1));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    drain("drain_en");
    idle(6);
    #3;
    check("final_busy", W'(busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule
